key_debounce_pulse: RTL



---
 rtl/key_debounce_pulse.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/key_debounce_pulse.sv
// key_debounce_pulse
// Conditions one raw push-button into a debounced level plus single-cycle
// press/release strobes, and keeps an 8-bit wrap-around press counter.
// press_pulse is meant to drive the enable of a downstream register, so each
// accepted press loads that register exactly once.
//
// Optional feature: define AUTO_REPEAT_EN to add auto-repeat while the key
// stays held (first repeat after REPEAT_DELAY cycles, then every
// REPEAT_PERIOD cycles). Without the macro no repeat logic exists and the
// REPEAT_* parameters are not declared.
module key_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter bit ACTIVE_LOW      = 1'b1
`ifdef AUTO_REPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_raw,
    output logic       key_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic [7:0] press_count
);

    // Raw level of a released key; synchronisers reset here so that reset
    // itself never looks like a press.
    localparam logic RELEASED = ACTIVE_LOW ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE         = 2'd0,
        S_PRESS_WAIT   = 2'd1,
        S_HELD         = 2'd2,
        S_RELEASE_WAIT = 2'd3
    } state_t;

    logic             r_sync1;
    logic             r_sync2;
    logic             w_sync;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_cnt_done;
    logic             w_accept_press;
    logic             w_accept_release;
    logic             w_rep_fire;

    logic             w_level_nxt;
    logic             w_press_nxt;
    logic             w_release_nxt;
    logic [7:0]       w_count_nxt;

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_sync1 <= RELEASED;
            r_sync2 <= RELEASED;
        end else begin
            r_sync1 <= key_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Normalise polarity so that pressed reads as 1 from here on
    assign w_sync     = ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign w_cnt_done = (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // FSM state and debounce counter register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: a change is accepted only after it has been seen
    // stable for DEBOUNCE_CYCLES counted cycles; any bounce restarts it.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_accept_press   = 1'b0;
        w_accept_release = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_sync) begin
                    w_state_nxt = S_PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_PRESS_WAIT: begin
                if (!w_sync) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt    = S_HELD;
                    w_cnt_nxt      = '0;
                    w_accept_press = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_HELD: begin
                if (!w_sync) begin
                    w_state_nxt = S_RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            S_RELEASE_WAIT: begin
                if (w_sync) begin
                    w_state_nxt = S_HELD;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt      = S_IDLE;
                    w_cnt_nxt        = '0;
                    w_accept_release = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef AUTO_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);

    logic [REP_W-1:0] r_rep;
    logic             r_rep_armed;
    logic             w_rep_stay;

    // Repeat only counts while the key remains held; any visit to
    // RELEASE_WAIT clears it, so a bounce restarts the initial delay.
    assign w_rep_stay = (r_state == S_HELD) && w_sync;

    // Repeat strobe: initial delay first, then the shorter period
    always_comb begin
        w_rep_fire = 1'b0;
        if (w_rep_stay) begin
            if (r_rep_armed) begin
                w_rep_fire = (r_rep == REP_W'(REPEAT_PERIOD - 1));
            end else begin
                w_rep_fire = (r_rep == REP_W'(REPEAT_DELAY - 1));
            end
        end
    end

    // Repeat counter and first-repeat-done flag
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rep       <= '0;
            r_rep_armed <= 1'b0;
        end else if (!w_rep_stay) begin
            r_rep       <= '0;
            r_rep_armed <= 1'b0;
        end else if (w_rep_fire) begin
            r_rep       <= '0;
            r_rep_armed <= 1'b1;
        end else begin
            r_rep <= r_rep + REP_W'(1);
        end
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    // Output next-values; all outputs are registered below
    always_comb begin
        w_press_nxt   = w_accept_press | w_rep_fire;
        w_release_nxt = w_accept_release;
        w_level_nxt   = key_level;
        if (w_accept_press) begin
            w_level_nxt = 1'b1;
        end else if (w_accept_release) begin
            w_level_nxt = 1'b0;
        end
        w_count_nxt = press_count;
        if (w_press_nxt) begin
            w_count_nxt = press_count + 8'd1;
        end
    end

    // Output registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            press_count   <= 8'd0;
        end else begin
            key_level     <= w_level_nxt;
            press_pulse   <= w_press_nxt;
            release_pulse <= w_release_nxt;
            press_count   <= w_count_nxt;
        end
    end

endmodule
